// File: rtl/neander_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : neander_pkg
//  Description : Shared types and constants for the memory access block:
//                storage geometry and the access FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package neander_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int CNT_W     = 4;

    // Access FSM states, explicitly encoded on two bits
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage : neander_pkg
`default_nettype wire

// File: rtl/mem_array_256x8.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array_256x8
//  Description : 256 x 8 storage with one synchronous write port and one
//                registered read port. The array itself is never reset; only
//                the read-data register is.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_array_256x8
    import neander_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Synchronous write port; contents survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value until the next read enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule : mem_array_256x8
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access
//  Description : Wait-state memory access controller. Accepts a read or
//                write request in IDLE, waits WAIT_STATES cycles, performs
//                the access, then pulses ack. Also offers an idle-time
//                preload write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access
    import neander_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy
);

    // Counter is preloaded with WAIT_STATES-1 so WAIT lasts exactly
    // WAIT_STATES cycles, leaving when it reads zero.
    localparam logic             c_HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [CNT_W-1:0] c_WAIT_LOAD = (WAIT_STATES > 0) ?
                                               CNT_W'(WAIT_STATES - 1) :
                                               '0;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_wr;
    logic              r_ack;
    logic              r_busy;

    logic              w_req;
    logic              w_acc_we;
    logic              w_acc_re;
    logic              w_init_we;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;

    assign w_req = rd_req | wr_req;

    // Access FSM with registered ack/busy. ack is raised on the edge that
    // leaves DONE, so it lines up with the read data being stable and
    // lands WAIT_STATES+2 edges after acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_is_wr <= 1'b0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_is_wr <= wr_req;   // write wins over a simultaneous read
                        r_busy  <= 1'b1;
                        if (c_HAS_WAIT) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= c_WAIT_LOAD;
                        end else begin
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_ACCESS: begin
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_ack   <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Memory port steering: the latched access owns the array in ACCESS,
    // preload writes only slip in while IDLE with no request pending.
    always_comb begin
        w_acc_we    = (r_state == ST_ACCESS) &  r_is_wr;
        w_acc_re    = (r_state == ST_ACCESS) & ~r_is_wr;
        w_init_we   = (r_state == ST_IDLE) & init_we & ~w_req;
        w_mem_we    = w_acc_we | w_init_we;
        w_mem_waddr = w_acc_we ? r_addr  : init_addr;
        w_mem_wdata = w_acc_we ? r_wdata : init_data;
    end

    mem_array_256x8 u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (w_mem_we),
        .waddr (w_mem_waddr),
        .wdata (w_mem_wdata),
        .re    (w_acc_re),
        .raddr (r_addr),
        .rdata (rdata)
    );

    assign ack  = r_ack;
    assign busy = r_busy;

endmodule : mem_access
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access
//  Description : Self-checking bench for mem_access. Two instances are
//                exercised: one with two wait states and one with none.
//                A reference memory per instance predicts read data, and
//                ack/busy are predicted from the fixed access latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    logic       clk = 1'b0;
    logic [1:0] rst;
    logic [1:0] rd_req;
    logic [1:0] wr_req;
    logic [1:0] init_we;
    logic [7:0] addr      [2];
    logic [7:0] wdata     [2];
    logic [7:0] init_addr [2];
    logic [7:0] init_data [2];

    logic [7:0] rdata0, rdata2;
    logic       ack0, ack2, busy0, busy2;

    logic [7:0] ref_mem [2][256];
    logic [7:0] exp_rd  [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Index 0: no wait states
    mem_access #(.WAIT_STATES(0)) u_dut0 (
        .clk       (clk),
        .rst       (rst[0]),
        .addr      (addr[0]),
        .wdata     (wdata[0]),
        .rd_req    (rd_req[0]),
        .wr_req    (wr_req[0]),
        .init_we   (init_we[0]),
        .init_addr (init_addr[0]),
        .init_data (init_data[0]),
        .rdata     (rdata0),
        .ack       (ack0),
        .busy      (busy0)
    );

    // Index 1: two wait states
    mem_access #(.WAIT_STATES(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst[1]),
        .addr      (addr[1]),
        .wdata     (wdata[1]),
        .rd_req    (rd_req[1]),
        .wr_req    (wr_req[1]),
        .init_we   (init_we[1]),
        .init_addr (init_addr[1]),
        .init_data (init_data[1]),
        .rdata     (rdata2),
        .ack       (ack2),
        .busy      (busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ws(input int sel);
        return (sel == 1) ? 2 : 0;
    endfunction

    function automatic logic obs_ack(input int sel);
        return (sel == 1) ? ack2 : ack0;
    endfunction

    function automatic logic obs_busy(input int sel);
        return (sel == 1) ? busy2 : busy0;
    endfunction

    function automatic logic [7:0] obs_rd(input int sel);
        return (sel == 1) ? rdata2 : rdata0;
    endfunction

    // Preload one location through the idle-time init port (starts/ends just after a negedge)
    task automatic init_write(input int sel, input logic [7:0] a, input logic [7:0] d);
        init_we[sel]   = 1'b1;
        init_addr[sel] = a;
        init_data[sel] = d;
        @(posedge clk);
        @(negedge clk);
        init_we[sel]   = 1'b0;
        ref_mem[sel][a] = d;
    endtask

    // One request; ack expected exactly WAIT_STATES+2 edges after acceptance,
    // busy during the WAIT_STATES+2 cycles before it. With disturb set, inputs
    // are scrambled while busy; none of that may affect the result.
    task automatic access(input int sel, input bit wr, input bit rd,
                          input logic [7:0] a, input logic [7:0] d,
                          input bit disturb, input string tag);
        int w;
        w = ws(sel);
        addr[sel]   = a;
        wdata[sel]  = d;
        wr_req[sel] = wr;
        rd_req[sel] = rd;
        if (wr) ref_mem[sel][a] = d;
        else    exp_rd[sel]     = ref_mem[sel][a];
        @(posedge clk);
        for (int k = 0; k <= w + 5; k++) begin
            @(negedge clk);
            check({tag, "_ack"},  {31'd0, obs_ack(sel)},  {31'd0, (k == w + 2)});
            check({tag, "_busy"}, {31'd0, obs_busy(sel)}, {31'd0, (k <= w + 1)});
            if (wr || k >= w + 2)
                check({tag, "_rdata"}, {24'd0, obs_rd(sel)}, {24'd0, exp_rd[sel]});
            if (disturb && k <= w + 1) begin
                addr[sel]      = 8'($urandom);
                wdata[sel]     = 8'($urandom);
                rd_req[sel]    = 1'($urandom);
                wr_req[sel]    = 1'($urandom);
                init_we[sel]   = 1'($urandom);
                init_addr[sel] = 8'($urandom);
                init_data[sel] = 8'($urandom);
            end else begin
                rd_req[sel]  = 1'b0;
                wr_req[sel]  = 1'b0;
                init_we[sel] = 1'b0;
            end
        end
    endtask

    // Read request held through DONE: a second access starts right after the first ack
    task automatic back_to_back(input int sel, input logic [7:0] a);
        int w;
        w = ws(sel);
        addr[sel]   = a;
        rd_req[sel] = 1'b1;
        exp_rd[sel] = ref_mem[sel][a];
        @(posedge clk);
        for (int k = 0; k <= 2 * w + 6; k++) begin
            @(negedge clk);
            check("b2b_ack",  {31'd0, obs_ack(sel)},
                  {31'd0, (k == w + 2) || (k == 2 * w + 5)});
            check("b2b_busy", {31'd0, obs_busy(sel)},
                  {31'd0, (k <= w + 1) || (k >= w + 3 && k <= 2 * w + 4)});
            if (k == w + 2 || k == 2 * w + 5)
                check("b2b_rdata", {24'd0, obs_rd(sel)}, {24'd0, exp_rd[sel]});
            if (k >= w + 3) rd_req[sel] = 1'b0;
        end
    endtask

    initial begin
        rst     = 2'b00;
        rd_req  = 2'b00;
        wr_req  = 2'b00;
        init_we = 2'b00;
        for (int s = 0; s < 2; s++) begin
            addr[s]      = 8'h00;
            wdata[s]     = 8'h00;
            init_addr[s] = 8'h00;
            init_data[s] = 8'h00;
            exp_rd[s]    = 8'h00;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rdata0", {24'd0, rdata0}, 32'h00);
        check("rst_ack0",   {31'd0, ack0},   32'h0);
        check("rst_busy0",  {31'd0, busy0},  32'h0);
        check("rst_rdata2", {24'd0, rdata2}, 32'h00);
        check("rst_ack2",   {31'd0, ack2},   32'h0);
        check("rst_busy2",  {31'd0, busy2},  32'h0);
        rst = 2'b11;
        @(negedge clk);

        // Give every location a known value in both instances
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 256; a++)
                init_write(s, 8'(a), 8'($urandom));

        // Preload A5 at 10, read it back with two wait states
        init_write(1, 8'h10, 8'hA5);
        access(1, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0, "pre_rd");

        // Write 3C to FF (rdata must not move), then read it back
        access(1, 1'b1, 1'b0, 8'hFF, 8'h3C, 1'b0, "wr_ff");
        access(1, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, "rd_ff");

        // Simultaneous read and write: the write wins
        access(1, 1'b1, 1'b1, 8'h20, 8'h77, 1'b0, "both");
        access(1, 1'b0, 1'b1, 8'h20, 8'h00, 1'b0, "rd_20");

        // No wait states, with requests pulsed while busy
        access(0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, "ws0_rd");
        access(0, 1'b1, 1'b0, 8'h5A, 8'hC3, 1'b1, "ws0_wr");
        access(0, 1'b0, 1'b1, 8'h5A, 8'h00, 1'b0, "ws0_rb");

        // Reset dropped during WAIT of a write aborts it
        init_write(1, 8'h40, 8'h9E);
        addr[1]   = 8'h40;
        wdata[1]  = 8'h55;
        wr_req[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr_req[1] = 1'b0;
        check("abort_busy_pre", {31'd0, busy2}, 32'h1);
        #2 rst[1] = 1'b0;
        #1;
        check("abort_busy",  {31'd0, busy2},  32'h0);
        check("abort_ack",   {31'd0, ack2},   32'h0);
        check("abort_rdata", {24'd0, rdata2}, 32'h00);
        exp_rd[1] = 8'h00;
        @(negedge clk);
        rst[1] = 1'b1;
        access(1, 1'b0, 1'b1, 8'h40, 8'h00, 1'b0, "abort_rb");

        // Preload strobe during an active read is ignored
        init_write(1, 8'h60, 8'h11);
        addr[1]   = 8'h10;
        rd_req[1] = 1'b1;
        exp_rd[1] = ref_mem[1][8'h10];
        @(posedge clk);
        @(negedge clk);
        rd_req[1]    = 1'b0;
        init_we[1]   = 1'b1;
        init_addr[1] = 8'h60;
        init_data[1] = 8'hEE;
        @(negedge clk);
        init_we[1] = 1'b0;
        repeat (4) @(negedge clk);
        check("initbusy_rdata", {24'd0, rdata2}, {24'd0, exp_rd[1]});
        access(1, 1'b0, 1'b1, 8'h60, 8'h00, 1'b0, "initbusy_rb");

        // Back-to-back on both instances
        back_to_back(1, 8'hFF);
        back_to_back(0, 8'h5A);

        // Randomised traffic with disturbance while busy
        repeat (40) begin
            int sel;
            int op;
            sel = int'($urandom_range(0, 1));
            op  = int'($urandom_range(0, 2));
            access(sel, op != 0, op != 1, 8'($urandom), 8'($urandom), 1'b1, "rnd");
        end

        // Read back a spread of locations in both instances
        for (int i = 0; i < 16; i++) begin
            access(i % 2, 1'b0, 1'b1, 8'($urandom), 8'h00, 1'b0, "sweep");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_access
`default_nettype wire

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 2, giving the number of wait cycles per access (legal range 0..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port addr, input, 8 bits: memory address driven by the address register.
REQ-005 The block SHALL have port wdata, input, 8 bits: write data driven by the data register.
REQ-006 The block SHALL have port rd_req, input, 1 bit: read request.
REQ-007 The block SHALL have port wr_req, input, 1 bit: write request.
REQ-008 The block SHALL have port init_we, input, 1 bit: preload write strobe.
REQ-009 The block SHALL have port init_addr, input, 8 bits: preload address.
REQ-010 The block SHALL have port init_data, input, 8 bits: preload data.
REQ-011 The block SHALL have port rdata, output, 8 bits: registered read data.
REQ-012 The block SHALL have port ack, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port busy, output, 1 bit: an access is in progress.

Function
REQ-014 The block SHALL contain a 256 x 8 storage array, indexed directly by the 8-bit address with no wrap logic.
REQ-015 The block SHALL implement an FSM with states IDLE, WAIT, ACCESS and DONE.
REQ-016 In IDLE, a request SHALL be accepted when rd_req or wr_req is high at a rising edge; addr, wdata and the operation type are latched on that edge.
REQ-017 When rd_req and wr_req are both high in the same cycle, the write SHALL win and the read SHALL be dropped.
REQ-018 On acceptance the FSM SHALL go to WAIT when WAIT_STATES>0, otherwise directly to ACCESS.
REQ-019 The FSM SHALL stay in WAIT for exactly WAIT_STATES cycles, counted by a 4-bit down-counter, and then go to ACCESS.
REQ-020 In ACCESS, a write SHALL store the latched wdata at the latched addr, and a read SHALL load rdata from the array; the FSM then goes to DONE.
REQ-021 In DONE, ack SHALL be high for exactly one cycle and the FSM SHALL return to IDLE.
REQ-022 Latency SHALL be fixed: for a request accepted at edge N, ack is high in the cycle after edge N+WAIT_STATES+2.
REQ-023 busy SHALL be high in WAIT, ACCESS and DONE, and low in IDLE.
REQ-024 Requests arriving while busy SHALL be ignored; they are not queued.
REQ-025 Changes on addr or wdata after acceptance SHALL NOT affect the access in progress.
REQ-026 rdata SHALL hold its value until the next read reaches ACCESS; writes SHALL NOT change rdata.
REQ-027 init_we SHALL write init_data to init_addr only in IDLE with both rd_req and wr_req low; otherwise it is ignored.
REQ-028 Back-to-back operation: a request held high through DONE SHALL be accepted again in the following IDLE cycle.

Reset
REQ-029 While rst is low, the FSM SHALL be IDLE, the wait counter 0, rdata 8'h00, ack 0 and busy 0, applied asynchronously.
REQ-030 Reset SHALL NOT clear the storage array; contents after power-up are undefined until written.
REQ-031 Reset asserted mid-access SHALL abort the access: a write not yet in ACCESS is not performed, and no ack is issued.

Structure
REQ-032 The FSM state enum and the constants MEM_DEPTH=256 and DATA_W=8 SHALL live in the shared package neander_pkg.
REQ-033 The storage array SHALL be one sub-module, mem_array_256x8, with a synchronous write port and a registered read port; the FSM SHALL remain in mem_access.

Verification
REQ-034 Preload 8'hA5 at 8'h10 via init_we, then read 8'h10 with WAIT_STATES=2 -> ack in the 4th cycle after acceptance, rdata=8'hA5.
REQ-035 Write 8'h3C to 8'hFF, then read 8'hFF -> rdata=8'h3C; rdata is unchanged during the write.
REQ-036 rd_req and wr_req high together, addr=8'h20, wdata=8'h77 -> write performed, rdata unchanged; a later read returns 8'h77.
REQ-037 With WAIT_STATES=0, read 8'h00 -> ack on the 2nd cycle after acceptance; a second request pulsed while busy -> ignored, one ack only.
REQ-038 Drop rst during WAIT of a write of 8'h55 to 8'h40 -> busy=0 and ack=0 immediately; a later read of 8'h40 returns the old value.
REQ-039 init_we pulsed during an active read -> ignored; the target location keeps its previous value.
